// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I multicycle controller.
// Contents: FSM state encoding, the opcodes the controller recognises, and
// the encodings of the ResultSrc / ALUSrcA / ALUSrcB / ALUOp / ImmSrc selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/immdec_sel.sv
// Immediate-format select: maps an opcode to the ImmSrc code consumed by the
// immediate extender. Purely combinational so the pipelined decoder can reuse it.
// Ports:
//   op_i       instr[6:0]
//   imm_src_o  000 I, 001 S, 010 B, 011 J, 100 U (000 for anything unlisted)
module immdec_sel
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      OP_LUI:  imm_src_o = IMM_U;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM. Sequences fetch / decode / execute /
// memory / writeback, waits on a memory ready handshake, supports LUI, traps
// on unsupported opcodes and counts retired instructions.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   op                    instr[6:0] from the instruction register
//   mem_ready             memory access completes this cycle
//   RegWrite, MemWrite    register-file / data-memory write strobes
//   IRWrite, PCUpdate     instruction register load, unconditional PC write
//   Branch                conditional PC write (qualified by Zero in datapath)
//   AdrSrc                memory address select (0 PC, 1 Result)
//   ResultSrc             00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUSrcA / ALUSrcB     ALU operand selects
//   ALUOp                 00 add, 01 sub, 10 funct-decoded (to aludec)
//   ImmSrc                immediate format, combinational from op
//   retire                pulse on the last cycle of each instruction
//   illegal_op            sticky unsupported-opcode flag
//   instret               retired-instruction count, wraps silently
module main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_LUI        = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  logic             ready;
  logic             rw_raw, mw_raw, irw_raw, pcu_raw, br_raw, ret_raw;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  immdec_sel u_immdec_sel (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) illegal_q <= 1'b1;
      if (ret_raw) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          OP_LUI:       state_d = EN_LUI ? LUI : TRAP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (ready) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;  // ALUWB writes rd = PC+4 and retires
      LUI:      state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    rw_raw    = 1'b0;
    mw_raw    = 1'b0;
    irw_raw   = 1'b0;
    pcu_raw   = 1'b0;
    br_raw    = 1'b0;
    ret_raw   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        irw_raw   = ready;
        pcu_raw   = ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw_raw    = 1'b1;
        ret_raw   = 1'b1;
      end
      MEMWRITE: begin
        // Write strobe held through the whole wait; retire only on completion.
        AdrSrc  = 1'b1;
        mw_raw  = 1'b1;
        ret_raw = ready;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        rw_raw  = 1'b1;
        ret_raw = 1'b1;
      end
      BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_SUB;
        br_raw  = 1'b1;
        ret_raw = 1'b1;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        pcu_raw = 1'b1;
      end
      LUI: begin
        ResultSrc = RES_IMM;
        rw_raw    = 1'b1;
        ret_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so an in-flight instruction is killed
  // the moment reset rises, not at the next clock edge.
  assign RegWrite   = rw_raw  & ~reset;
  assign MemWrite   = mw_raw  & ~reset;
  assign IRWrite    = irw_raw & ~reset;
  assign PCUpdate   = pcu_raw & ~reset;
  assign Branch     = br_raw  & ~reset;
  assign retire     = ret_raw & ~reset;
  assign illegal_op = illegal_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default parameters
  logic        reset = 1'b1;
  logic [6:0]  op = 7'h00;
  logic        mem_ready = 1'b0;
  logic        RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc, retire, illegal_op;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic [31:0] instret;

  // DUT 2: EN_LUI=0, CNT_W=4
  logic        reset2 = 1'b1;
  logic [6:0]  op2 = 7'h00;
  logic        rdy2 = 1'b0;
  logic        RegWrite2, MemWrite2, IRWrite2, PCUpdate2, Branch2, AdrSrc2, retire2, illegal2;
  logic [1:0]  ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2;
  logic [2:0]  ImmSrc2;
  logic [3:0]  instret2;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
    .Branch(Branch), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .retire(retire),
    .illegal_op(illegal_op), .instret(instret)
  );

  main_fsm #(.MEM_HANDSHAKE(1'b1), .EN_LUI(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .op(op2), .mem_ready(rdy2),
    .RegWrite(RegWrite2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .PCUpdate(PCUpdate2),
    .Branch(Branch2), .AdrSrc(AdrSrc2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .ImmSrc(ImmSrc2), .retire(retire2),
    .illegal_op(illegal2), .instret(instret2)
  );

  // {RegWrite,MemWrite,IRWrite,PCUpdate,Branch,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,retire}
  logic [14:0] outs, outs2;
  assign outs  = {RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire};
  assign outs2 = {RegWrite2, MemWrite2, IRWrite2, PCUpdate2, Branch2, AdrSrc2,
                  ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2, retire2};

  localparam logic [14:0] E_FETCH_R = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0};
  localparam logic [14:0] E_FETCH_W = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0};
  localparam logic [14:0] E_RST     = E_FETCH_W;
  localparam logic [14:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0};
  localparam logic [14:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0};
  localparam logic [14:0] E_MEMREAD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] E_MEMWB   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,1'b1};
  localparam logic [14:0] E_MEMWR_W = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] E_MEMWR_R = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b1};
  localparam logic [14:0] E_EXR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0};
  localparam logic [14:0] E_EXI     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0};
  localparam logic [14:0] E_ALUWB   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1};
  localparam logic [14:0] E_BEQ     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b00,2'b01,1'b1};
  localparam logic [14:0] E_JAL     = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0};
  localparam logic [14:0] E_LUI     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,2'b00,1'b1};
  localparam logic [14:0] E_ZERO    = 15'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic step(input logic [6:0] o, input logic r);
    @(negedge clk);
    op = o;
    mem_ready = r;
    #1;
  endtask

  task automatic step2(input logic [6:0] o, input logic r);
    @(negedge clk);
    op2 = o;
    rdy2 = r;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    op = OP_LW;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (outs !== E_RST) begin
      n_fail++; $display("FAIL reset_outs got %b want %b", outs, E_RST);
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL reset_instret got %0d want 0", instret);
    end
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal got %b want 0", illegal_op);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (outs !== E_FETCH_W) begin
      n_fail++; $display("FAIL reset_release_outs got %b want %b", outs, E_FETCH_W);
    end
  endtask

  task automatic test_lw;
    logic [14:0] ex [5];
    ex = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
    for (int i = 0; i < 5; i++) begin
      step(OP_LW, 1'b1);
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++; $display("FAIL lw_cyc%0d got %b want %b", i, outs, ex[i]);
      end
      n_cmp++;
      if (instret !== 32'd0) begin
        n_fail++; $display("FAIL lw_instret_cyc%0d got %0d want 0", i, instret);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (instret !== 32'd1) begin
      n_fail++; $display("FAIL lw_instret_after got %0d want 1", instret);
    end
  endtask

  task automatic test_sw;
    logic [14:0] ex [7];
    logic        rd [7];
    int          mw_cnt;
    ex = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_MEMWR_W, E_MEMWR_W, E_MEMWR_R};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    mw_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step(OP_SW, rd[i]);
      if (MemWrite === 1'b1) mw_cnt++;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++; $display("FAIL sw_cyc%0d got %b want %b", i, outs, ex[i]);
      end
    end
    n_cmp++;
    if (mw_cnt != 4) begin
      n_fail++; $display("FAIL sw_memwrite_cycles got %0d want 4", mw_cnt);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (instret !== 32'd2) begin
      n_fail++; $display("FAIL sw_instret got %0d want 2", instret);
    end
  endtask

  task automatic test_fetch_stall;
    logic [14:0] ex [6];
    logic        rd [6];
    ex = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_EXR, E_ALUWB};
    rd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(OP_R, rd[i]);
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++; $display("FAIL stall_cyc%0d got %b want %b", i, outs, ex[i]);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (instret !== 32'd3) begin
      n_fail++; $display("FAIL stall_instret got %0d want 3", instret);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0]  ops [18];
    logic [14:0] ex  [18];
    logic [2:0]  imm [5];
    int          k;
    ops = '{OP_BEQ, OP_BEQ, OP_LW,
            OP_JAL, OP_JAL, OP_SW, 7'h00,
            OP_LUI, OP_LUI, OP_R,
            OP_R,   OP_R,   OP_LW, OP_BEQ,
            OP_I,   OP_I,   OP_JAL, 7'h7f};
    ex  = '{E_FETCH_R, E_DECODE, E_BEQ,
            E_FETCH_R, E_DECODE, E_JAL, E_ALUWB,
            E_FETCH_R, E_DECODE, E_LUI,
            E_FETCH_R, E_DECODE, E_EXR, E_ALUWB,
            E_FETCH_R, E_DECODE, E_EXI, E_ALUWB};
    imm = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b000};
    k = 0;
    for (int i = 0; i < 18; i++) begin
      step(ops[i], 1'b1);
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++; $display("FAIL b2b_cyc%0d got %b want %b", i, outs, ex[i]);
      end
      if (ex[i] == E_DECODE) begin
        n_cmp++;
        if (ImmSrc !== imm[k]) begin
          n_fail++; $display("FAIL b2b_immsrc%0d got %b want %b", k, ImmSrc, imm[k]);
        end
        k++;
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (instret !== 32'd8) begin
      n_fail++; $display("FAIL b2b_instret got %0d want 8", instret);
    end
  endtask

  task automatic test_trap;
    step(OP_LW, 1'b1);
    step(7'b1111111, 1'b1);
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL trap_pre_illegal got %b want 0", illegal_op);
    end
    for (int i = 0; i < 3; i++) begin
      step(OP_LW, 1'b1);
      n_cmp++;
      if (illegal_op !== 1'b1) begin
        n_fail++; $display("FAIL trap_illegal_cyc%0d got %b want 1", i, illegal_op);
      end
      n_cmp++;
      if (outs !== E_ZERO) begin
        n_fail++; $display("FAIL trap_outs_cyc%0d got %b want %b", i, outs, E_ZERO);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL trap_reset_illegal got %b want 0", illegal_op);
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL trap_reset_instret got %0d want 0", instret);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lui_disabled;
    @(negedge clk);
    rdy2 = 1'b0;
    reset2 = 1'b0;
    step2(OP_LUI, 1'b1);
    step2(OP_LUI, 1'b1);
    n_cmp++;
    if (ImmSrc2 !== 3'b100) begin
      n_fail++; $display("FAIL luidis_immsrc got %b want 100", ImmSrc2);
    end
    step2(OP_LUI, 1'b1);
    n_cmp++;
    if (illegal2 !== 1'b1) begin
      n_fail++; $display("FAIL luidis_illegal got %b want 1", illegal2);
    end
    n_cmp++;
    if (outs2 !== E_ZERO) begin
      n_fail++; $display("FAIL luidis_outs got %b want %b", outs2, E_ZERO);
    end
    @(negedge clk);
    reset2 = 1'b1;
    rdy2 = 1'b0;
    #1;
    n_cmp++;
    if (illegal2 !== 1'b0) begin
      n_fail++; $display("FAIL luidis_reset_illegal got %b want 0", illegal2);
    end
    @(negedge clk);
    reset2 = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset;
    logic [3:0] want;
    for (int n = 1; n <= 17; n++) begin
      repeat (3) step2(OP_BEQ, 1'b1);
      @(posedge clk);
      #1;
      want = 4'(n % 16);
      n_cmp++;
      if (instret2 !== want) begin
        n_fail++; $display("FAIL wrap_instret_n%0d got %0d want %0d", n, instret2, want);
      end
    end
    repeat (4) step2(OP_LW, 1'b1);
    step2(OP_LW, 1'b1);
    n_cmp++;
    if (outs2 !== E_MEMWB) begin
      n_fail++; $display("FAIL arst_memwb got %b want %b", outs2, E_MEMWB);
    end
    #1;
    reset2 = 1'b1;
    #1;
    n_cmp++;
    if (RegWrite2 !== 1'b0 || retire2 !== 1'b0) begin
      n_fail++; $display("FAIL arst_strobes got RegWrite=%b retire=%b want 0 0", RegWrite2, retire2);
    end
    n_cmp++;
    if (outs2 !== E_RST) begin
      n_fail++; $display("FAIL arst_state got %b want %b", outs2, E_RST);
    end
    n_cmp++;
    if (instret2 !== 4'd0) begin
      n_fail++; $display("FAIL arst_instret got %0d want 0", instret2);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (instret2 !== 4'd0 || outs2 !== E_RST) begin
      n_fail++; $display("FAIL arst_hold got instret=%0d outs=%b want 0 %b", instret2, outs2, E_RST);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_fetch_stall();
    test_back_to_back();
    test_trap();
    test_lui_disabled();
    test_wrap_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
